// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL lock qualifier; define LOCK_LOSS_IRQ_EN to add the sticky loss_irq flag with irq_clr
module pll_lock_sequencer #(
  parameter int STABLE_CYCLES = 64,
  parameter int CNT_W         = 8,
  parameter int LOSS_CNT_W    = 4
) (
  input  logic                  pllclk,
  input  logic                  rst,
  input  logic                  lock_in,
  input  logic                  clken_in,
`ifdef LOCK_LOSS_IRQ_EN
  input  logic                  irq_clr,
  output logic                  loss_irq,
`endif
  output logic                  sync_rst,
  output logic                  ready,
  output logic                  run_en,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [1:0]            state
);
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    STABILIZE = 2'b01,
    RUN       = 2'b10,
    LOST      = 2'b11
  } state_t;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
  logic [1:0]            lock_sync_q, clken_sync_q;
  logic                  lock_s, clken_s;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                  sync_rst_q, sync_rst_d;
  logic                  ready_q, ready_d;
  logic                  run_en_q, run_en_d;
  assign lock_s  = lock_sync_q[1];
  assign clken_s = clken_sync_q[1];
  // two-flop synchronisers bringing lock and clock enable into the pllclk domain
  always_ff @(posedge pllclk or posedge rst) begin
    if (rst) begin
      lock_sync_q  <= '0;
      clken_sync_q <= '0;
    end else begin
      lock_sync_q  <= {lock_sync_q[0], lock_in};
      clken_sync_q <= {clken_sync_q[0], clken_in};
    end
  end
  // lock qualification: any lock drop in STABILIZE restarts the count from zero
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_cnt_d = loss_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d   = '0;
        state_d = lock_s ? STABILIZE : WAIT_LOCK;
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d    = LOST;
          loss_cnt_d = (loss_cnt_q == '1) ? loss_cnt_q : loss_cnt_q + LOSS_CNT_W'(1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    sync_rst_d = (state_d != RUN);
    ready_d    = (state_d == RUN);
    run_en_d   = (state_d == RUN) && clken_s;
  end
  // state, counters and registered outputs all update on the same edge
  always_ff @(posedge pllclk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      loss_cnt_q <= '0;
      sync_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      run_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loss_cnt_q <= loss_cnt_d;
      sync_rst_q <= sync_rst_d;
      ready_q    <= ready_d;
      run_en_q   <= run_en_d;
    end
  end
`ifdef LOCK_LOSS_IRQ_EN
  logic loss_irq_q, loss_irq_d;
  // sticky loss flag; a new loss on the clearing edge keeps it set
  always_comb begin
    loss_irq_d = (state_q == RUN && state_d == LOST) ? 1'b1 : (irq_clr ? 1'b0 : loss_irq_q);
  end
  // loss flag register
  always_ff @(posedge pllclk or posedge rst) begin
    if (rst) loss_irq_q <= 1'b0;
    else     loss_irq_q <= loss_irq_d;
  end
  assign loss_irq = loss_irq_q;
`endif
  assign sync_rst   = sync_rst_q;
  assign ready      = ready_q;
  assign run_en     = run_en_q;
  assign loss_count = loss_cnt_q;
  assign state      = state_q;
endmodule
